// File: rtl/fft_pkg.sv
// Shared types and address helpers for the FFT sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } fft_state_t;

  // Rotate the low n2 bits of value left by amount (amount <= n2).
  function automatic logic [31:0] rotl(input logic [31:0] value,
                                       input int unsigned amount,
                                       input int unsigned n2);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (32'd1 << n2) - 32'd1;
    v    = value & mask;
    return ((v << amount) | (v >> (n2 - amount))) & mask;
  endfunction

  // Twiddle address: j as an (n2-1)-bit field, keep its upper i bits.
  function automatic logic [31:0] tw_mask(input int unsigned i,
                                          input logic [31:0] j,
                                          input int unsigned n2);
    int unsigned w;
    logic [31:0] keep;
    w    = n2 - 1;
    keep = ~((32'd1 << (w - i)) - 32'd1) & ((32'd1 << w) - 32'd1);
    return j & keep;
  endfunction

endpackage

// File: rtl/fft_adr_gen.sv
// Butterfly operand addresses and twiddle address for (stage i, butterfly j).
module fft_adr_gen
  import fft_pkg::*;
#(
  parameter int N_2 = 5,
  parameter int IW  = 3
) (
  input  logic [IW-1:0]  i,
  input  logic [N_2-2:0] j,
  output logic [N_2-1:0] adra,
  output logic [N_2-1:0] adrb,
  output logic [N_2-2:0] tw
);

  // Operands 2j and 2j+1 rotated by the stage number; twiddle from the masked index.
  always_comb begin
    adra = N_2'(rotl(32'({j, 1'b0}), 32'(i), N_2));
    adrb = N_2'(rotl(32'({j, 1'b1}), 32'(i), N_2));
    tw   = (N_2 - 1)'(tw_mask(32'(i), 32'(j), N_2));
  end

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: stage/butterfly walk, RAM control, twiddle prefetch.
//
// state | meaning
// IDLE  | waiting for start, all outputs quiet
// PRE   | one bubble per stage so the twiddle ROM sees butterfly 0's address
// RUN   | one butterfly per cycle, j = 0..N/2-1
// DONE  | transform complete, done held until next start
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           done,
  output logic           busy,
  output logic           rdsel,
  output logic           we0,
  output logic           we1,
  output logic [N_2-1:0] adr0a,
  output logic [N_2-1:0] adr0b,
  output logic [N_2-1:0] adr1a,
  output logic [N_2-1:0] adr1b,
  output logic [N_2-2:0] twiddleadr,
  output logic           resultsel
);

  localparam int IW = (N_2 > 1) ? $clog2(N_2) : 1;
  localparam logic [IW-1:0]  I_LAST = IW'(N_2 - 1);
  localparam logic [N_2-2:0] J_LAST = '1;
  localparam logic [N_2-2:0] J_ONE  = (N_2 - 1)'(1);

  fft_state_t     state;
  logic [IW-1:0]  i;
  logic [N_2-2:0] j;
  logic [N_2-2:0] j_next;
  logic [N_2-1:0] cur_adra;
  logic [N_2-1:0] cur_adrb;
  logic [N_2-2:0] cur_tw;
  logic [N_2-2:0] nxt_tw;
  logic [2*N_2-1:0] unused_nxt_adr;

  assign j_next = j + J_ONE;

  fft_adr_gen #(.N_2(N_2), .IW(IW)) u_adr_cur (
    .i    (i),
    .j    (j),
    .adra (cur_adra),
    .adrb (cur_adrb),
    .tw   (cur_tw)
  );

  // Second copy looks one butterfly ahead to cover the ROM's read latency.
  fft_adr_gen #(.N_2(N_2), .IW(IW)) u_adr_nxt (
    .i    (i),
    .j    (j_next),
    .adra (unused_nxt_adr[N_2-1:0]),
    .adrb (unused_nxt_adr[2*N_2-1:N_2]),
    .tw   (nxt_tw)
  );

  // State and stage/butterfly counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      i     <= '0;
      j     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_PRE;
            i     <= '0;
            j     <= '0;
          end
        end
        ST_PRE: state <= ST_RUN;
        ST_RUN: begin
          if (j == J_LAST) begin
            if (i == I_LAST) begin
              state <= ST_DONE;
            end else begin
              state <= ST_PRE;
              i     <= i + IW'(1);
              j     <= '0;
            end
          end else begin
            j <= j_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Moore output decode; anything outside PRE/RUN looks like reset.
  always_comb begin
    done       = (state == ST_DONE);
    busy       = (state == ST_PRE) || (state == ST_RUN);
    rdsel      = 1'b0;
    we0        = 1'b0;
    we1        = 1'b0;
    adr0a      = '0;
    adr0b      = '0;
    adr1a      = '0;
    adr1b      = '0;
    twiddleadr = '0;
    if (state == ST_PRE) begin
      twiddleadr = cur_tw;
    end else if (state == ST_RUN) begin
      rdsel      = i[0];
      we0        = i[0];
      we1        = ~i[0];
      adr0a      = cur_adra;
      adr0b      = cur_adrb;
      adr1a      = cur_adra;
      adr1b      = cur_adrb;
      twiddleadr = (j == J_LAST) ? '0 : nxt_tw;
    end
  end

  assign resultsel = 1'(N_2 % 2);

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl (N_2 = 5) against a cycle-count reference model.
module tb_fft_ctrl;

  localparam int N2    = 5;
  localparam int HALF  = 16;
  localparam int SLEN  = HALF + 1;
  localparam int TOTAL = N2 * SLEN;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        done, busy, rdsel, we0, we1, resultsel;
  logic [4:0]  adr0a, adr0b, adr1a, adr1b;
  logic [3:0]  twiddleadr;

  int tests = 0;
  int fails = 0;

  // model: mode 0 idle, 1 busy, 2 done; k = cycles since accepted start
  int mode = 0;
  int k = 0;
  logic [3:0] prev_tw = '0;

  fft_ctrl #(.width(16), .N_2(N2)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
    .rdsel(rdsel), .we0(we0), .we1(we1),
    .adr0a(adr0a), .adr0b(adr0b), .adr1a(adr1a), .adr1b(adr1b),
    .twiddleadr(twiddleadr), .resultsel(resultsel)
  );

  always #5 clk = ~clk;

  function automatic int m_rotl(input int v, input int amt);
    int r = 0;
    for (int b = 0; b < N2; b++)
      if ((v >> b) & 1) r = r | (1 << ((b + amt) % N2));
    return r;
  endfunction

  function automatic int m_tw(input int st, input int jj);
    int sh = (N2 - 1) - st;
    return ((jj >> sh) << sh) & 15;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int e_busy = 0, e_done = 0, e_rdsel = 0, e_we0 = 0, e_we1 = 0;
    int e_a = 0, e_b = 0, e_tw = 0;
    int st, pos, jj;
    if (mode == 2) e_done = 1;
    if (mode == 1) begin
      e_busy = 1;
      st  = k / SLEN;
      pos = k % SLEN;
      if (pos != 0) begin
        jj      = pos - 1;
        e_rdsel = st % 2;
        e_we0   = st % 2;
        e_we1   = 1 - (st % 2);
        e_a     = m_rotl(2 * jj, st);
        e_b     = m_rotl(2 * jj + 1, st);
        e_tw    = (jj < HALF - 1) ? m_tw(st, jj + 1) : 0;
        if (st == 0 && jj == 3) begin
          chk("s0j3_adra", 32'(adr0a), 6);
          chk("s0j3_adrb", 32'(adr0b), 7);
          chk("s0j3_tw", 32'(prev_tw), 0);
          chk("s0j3_we1", 32'(we1), 1);
          chk("s0j3_rdsel", 32'(rdsel), 0);
        end
        if (st == 4 && jj == 3) begin
          chk("s4j3_adra", 32'(adr0a), 3);
          chk("s4j3_adrb", 32'(adr0b), 19);
          chk("s4j3_tw", 32'(prev_tw), 3);
          chk("s4j3_we1", 32'(we1), 1);
        end
        if (st == 4 && jj == 2) chk("s4j2_prefetch", 32'(twiddleadr), 3);
        if (st == 3 && jj == 5) begin
          chk("s3j5_adra", 32'(adr1a), 18);
          chk("s3j5_adrb", 32'(adr1b), 26);
          chk("s3j5_tw", 32'(prev_tw), 4);
          chk("s3j5_we0", 32'(we0), 1);
          chk("s3j5_rdsel", 32'(rdsel), 1);
        end
      end
    end
    chk("busy", 32'(busy), e_busy);
    chk("done", 32'(done), e_done);
    chk("ctl", {29'd0, rdsel, we0, we1}, (e_rdsel << 2) | (e_we0 << 1) | e_we1);
    chk("adr", {12'd0, adr0a, adr0b, adr1a, adr1b},
        (e_a << 15) | (e_b << 10) | (e_a << 5) | e_b);
    chk("twiddle", 32'(twiddleadr), e_tw);
    chk("we_excl", 32'(we0 & we1), 0);
    chk("resultsel", 32'(resultsel), 1);
    prev_tw = twiddleadr;
  endtask

  task automatic step(input logic s, input logic r);
    start = s;
    reset = r;
    @(posedge clk);
    if (r) begin
      mode = 0; k = 0;
    end else if (mode != 1) begin
      if (s) begin mode = 1; k = 0; end
    end else begin
      k++;
      if (k == TOTAL) mode = 2;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    int cnt;
    int n;

    // reset and idle
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0);

    // single start pulse: busy length and done level
    step(1'b1, 1'b0);
    cnt = busy ? 1 : 0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      step(1'b0, 1'b0);
      if (busy === 1'b1) cnt++;
      n++;
    end
    chk("busy_len", cnt, TOTAL);
    chk("done_rise", 32'(done), 1);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0);
    chk("done_hold", 32'(done), 1);

    // restart with random start noise, reset at stage 2 j=7
    step(1'b1, 1'b0);
    n = 0;
    while (!(mode == 1 && k == 2 * SLEN + 8) && n < 200) begin
      step(1'($urandom_range(0, 1)), 1'b0);
      n++;
    end
    chk("reached_s2j7", k, 2 * SLEN + 8);
    step(1'b1, 1'b1);
    chk("reset_idle_busy", 32'(busy), 0);
    chk("reset_idle_we", {30'd0, we0, we1}, 0);

    // start held high the whole run
    step(1'b1, 1'b0);
    cnt = busy ? 1 : 0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      step(1'b1, 1'b0);
      if (busy === 1'b1) cnt++;
      n++;
    end
    chk("held_busy_len", cnt, TOTAL);
    chk("held_done", 32'(done), 1);
    step(1'b1, 1'b0);
    chk("held_restart_done", 32'(done), 0);
    chk("held_restart_busy", 32'(busy), 1);

    // random start/reset traffic
    for (int c = 0; c < 1500; c++)
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 99) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
